// File: rtl/auto_shutdown_multi.sv
// auto_shutdown_multi: independent per-zone lighting FSMs with a presence/manual-driven auto-shutdown timer.
// Optional pre-shutdown warning window is compiled in with AUTO_SHUTDOWN_WARN_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | lamp off, waiting for presence or manual on
// ACTIVE   | lamp on, zone occupied, counter held at 0
// COUNTING | lamp on, zone empty, counting toward shutdown
// WARN     | lamp on and dimmed, final WARN_T cycles before shutdown
// LOCKOUT  | lamp off after manual off, waits for presence to drop
module auto_shutdown_multi #(
   parameter  int N_ZONES = 4,
   parameter  int TIMEOUT = 30000,
   parameter  int WARN_T  = 3000,
   localparam int CNT_W   = $clog2(TIMEOUT)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_ZONES-1:0] presence_i,
   input  logic [N_ZONES-1:0] manual_on_i,
   input  logic [N_ZONES-1:0] manual_off_i,
   output logic [N_ZONES-1:0] lamp_o,
   output logic [N_ZONES-1:0] warn_o,
   output logic [N_ZONES-1:0] shutdown_o,
   output logic               any_on_o
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ACTIVE   = 3'd1,
      S_COUNTING = 3'd2,
      S_WARN     = 3'd3,
      S_LOCKOUT  = 3'd4
   } zone_state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

`ifdef AUTO_SHUTDOWN_WARN_EN
   localparam logic [CNT_W-1:0] CNT_WARN = CNT_W'(TIMEOUT - WARN_T - 1);

   if (WARN_T < 1 || WARN_T >= TIMEOUT) begin : g_bad_warn_t
      $error("auto_shutdown_multi: WARN_T must satisfy 1 <= WARN_T < TIMEOUT");
   end
`else
   logic unused_warn_t;
   assign unused_warn_t = (WARN_T != 0);
   assign warn_o        = '0;
`endif

   logic [N_ZONES-1:0] lamp_nxt;

   for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
      zone_state_t      st;
      zone_state_t      st_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             pulse_nxt;
      logic             lamp_q;
      logic             shut_q;
`ifdef AUTO_SHUTDOWN_WARN_EN
      logic             warn_nxt;
      logic             warn_q;
`endif

      // Priority: manual off > presence > manual on > counter compare.
      always_comb begin
         st_nxt    = st;
         cnt_nxt   = cnt;
         pulse_nxt = 1'b0;
         case (st)
            S_IDLE: begin
               cnt_nxt = '0;
               if (manual_off_i[z]) begin
                  st_nxt = S_IDLE;
               end else if (presence_i[z]) begin
                  st_nxt = S_ACTIVE;
               end else if (manual_on_i[z]) begin
                  st_nxt = S_COUNTING;
               end
            end
            S_ACTIVE: begin
               cnt_nxt = '0;
               if (manual_off_i[z]) begin
                  st_nxt = S_LOCKOUT;
               end else if (!presence_i[z]) begin
                  st_nxt = S_COUNTING;
               end
            end
            S_COUNTING: begin
               if (manual_off_i[z]) begin
                  st_nxt  = S_LOCKOUT;
                  cnt_nxt = '0;
               end else if (presence_i[z]) begin
                  st_nxt  = S_ACTIVE;
                  cnt_nxt = '0;
               end else if (manual_on_i[z]) begin
                  cnt_nxt = '0;
`ifdef AUTO_SHUTDOWN_WARN_EN
               end else if (cnt == CNT_WARN) begin
                  st_nxt  = S_WARN;
                  cnt_nxt = cnt + CNT_W'(1);
`else
               end else if (cnt == CNT_LAST) begin
                  st_nxt    = S_IDLE;
                  cnt_nxt   = '0;
                  pulse_nxt = 1'b1;
`endif
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
`ifdef AUTO_SHUTDOWN_WARN_EN
            S_WARN: begin
               if (manual_off_i[z]) begin
                  st_nxt  = S_LOCKOUT;
                  cnt_nxt = '0;
               end else if (presence_i[z]) begin
                  st_nxt  = S_ACTIVE;
                  cnt_nxt = '0;
               end else if (manual_on_i[z]) begin
                  st_nxt  = S_COUNTING;
                  cnt_nxt = '0;
               end else if (cnt == CNT_LAST) begin
                  st_nxt    = S_IDLE;
                  cnt_nxt   = '0;
                  pulse_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
`endif
            S_LOCKOUT: begin
               // Presence is ignored here so an occupied zone cannot relight right after manual off.
               cnt_nxt = '0;
               if (manual_off_i[z]) begin
                  st_nxt = S_LOCKOUT;
               end else if (manual_on_i[z]) begin
                  st_nxt = S_COUNTING;
               end else if (!presence_i[z]) begin
                  st_nxt = S_IDLE;
               end
            end
            default: begin
               st_nxt  = S_IDLE;
               cnt_nxt = '0;
            end
         endcase
      end

      assign lamp_nxt[z] = (st_nxt == S_ACTIVE) || (st_nxt == S_COUNTING) ||
                           (st_nxt == S_WARN);
`ifdef AUTO_SHUTDOWN_WARN_EN
      assign warn_nxt    = (st_nxt == S_WARN);
`endif

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st     <= S_IDLE;
            cnt    <= '0;
            lamp_q <= 1'b0;
            shut_q <= 1'b0;
`ifdef AUTO_SHUTDOWN_WARN_EN
            warn_q <= 1'b0;
`endif
         end else begin
            st     <= st_nxt;
            cnt    <= cnt_nxt;
            lamp_q <= lamp_nxt[z];
            shut_q <= pulse_nxt;
`ifdef AUTO_SHUTDOWN_WARN_EN
            warn_q <= warn_nxt;
`endif
         end
      end

      assign lamp_o[z]     = lamp_q;
      assign shutdown_o[z] = shut_q;
`ifdef AUTO_SHUTDOWN_WARN_EN
      assign warn_o[z]     = warn_q;
`endif
   end

   // Registered from the next-state lamp vector so it tracks lamp_o with identical latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_on_o <= 1'b0;
      end else begin
         any_on_o <= |lamp_nxt;
      end
   end

endmodule

// File: tb/tb_auto_shutdown_multi.sv
// Testbench for auto_shutdown_multi: directed scenarios checked against an occupancy/age model every cycle.
module tb_auto_shutdown_multi;

   localparam int N       = 2;
   localparam int TIMEOUT = 20;
   localparam int WARN_T  = 5;
`ifdef AUTO_SHUTDOWN_WARN_EN
   localparam bit WARN_EN = 1'b1;
`else
   localparam bit WARN_EN = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic [N-1:0] presence_i;
   logic [N-1:0] manual_on_i;
   logic [N-1:0] manual_off_i;
   logic [N-1:0] lamp_o;
   logic [N-1:0] warn_o;
   logic [N-1:0] shutdown_o;
   logic         any_on_o;

   auto_shutdown_multi #(.N_ZONES(N), .TIMEOUT(TIMEOUT), .WARN_T(WARN_T)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .presence_i   (presence_i),
      .manual_on_i  (manual_on_i),
      .manual_off_i (manual_off_i),
      .lamp_o       (lamp_o),
      .warn_o       (warn_o),
      .shutdown_o   (shutdown_o),
      .any_on_o     (any_on_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a zone is lit or not; a lit zone is either occupied or aging since the last absence.
   bit [N-1:0] lit;
   bit [N-1:0] aging;
   bit [N-1:0] locked;
   bit [N-1:0] pulse;
   int         age [N];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int z = 0; z < N; z++) begin
            lit[z]    <= 1'b0;
            aging[z]  <= 1'b0;
            locked[z] <= 1'b0;
            pulse[z]  <= 1'b0;
            age[z]    <= 0;
         end
      end else begin
         for (int z = 0; z < N; z++) begin
            automatic bit l  = lit[z];
            automatic bit t  = aging[z];
            automatic bit lk = locked[z];
            automatic bit p  = 1'b0;
            automatic int a  = age[z];
            if (manual_off_i[z]) begin
               if (l) begin
                  l = 1'b0; t = 1'b0; lk = 1'b1;
               end
            end else if (lk) begin
               if (manual_on_i[z]) begin
                  lk = 1'b0; l = 1'b1; t = 1'b1; a = 0;
               end else if (!presence_i[z]) begin
                  lk = 1'b0;
               end
            end else if (presence_i[z]) begin
               l = 1'b1; t = 1'b0; a = 0;
            end else if (manual_on_i[z]) begin
               l = 1'b1; t = 1'b1; a = 0;
            end else if (l) begin
               if (!t) begin
                  t = 1'b1; a = 0;
               end else begin
                  a = a + 1;
                  if (a == TIMEOUT) begin
                     l = 1'b0; t = 1'b0; p = 1'b1;
                  end
               end
            end
            lit[z]    <= l;
            aging[z]  <= t;
            locked[z] <= lk;
            pulse[z]  <= p;
            age[z]    <= a;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         automatic logic [N-1:0] e_warn = '0;
         for (int z = 0; z < N; z++)
            e_warn[z] = WARN_EN && lit[z] && aging[z] && (age[z] >= TIMEOUT - WARN_T);
         check("lamp_o",     int'(lamp_o),     int'(lit));
         check("warn_o",     int'(warn_o),     int'(e_warn));
         check("shutdown_o", int'(shutdown_o), int'(pulse));
         check("any_on_o",   int'(any_on_o),   int'(|lit));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Negedges are numbered from the one where the triggering input was driven.
   task automatic measure(input int z, output int t_warn, output int t_shut, output int n_lamp);
      t_warn = 0;
      t_shut = 0;
      n_lamp = 0;
      for (int n = 1; n <= 60 && t_shut == 0; n++) begin
         @(negedge clk);
         if (n == 1) manual_on_i[z] = 1'b0;
         if (t_warn == 0 && warn_o[z]) t_warn = n;
         if (shutdown_o[z]) t_shut = n;
         else if (lamp_o[z]) n_lamp++;
      end
   endtask

   task automatic check_timeout(input string name, input int z);
      int tw, ts, tl;
      measure(z, tw, ts, tl);
      check({name, "_warn_at"},  tw, WARN_EN ? TIMEOUT - WARN_T + 1 : 0);
      check({name, "_shut_at"},  ts, TIMEOUT + 1);
      check({name, "_lamp_len"}, tl, TIMEOUT);
   endtask

   initial begin
      rst_n        = 1'b0;
      presence_i   = '0;
      manual_on_i  = '0;
      manual_off_i = '0;
      step(2);
      check("rst_lamp", int'(lamp_o), 0);
      check("rst_warn", int'(warn_o), 0);
      check("rst_shut", int'(shutdown_o), 0);
      check("rst_any",  int'(any_on_o), 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      step(1);

      // basic timeout on zone 0
      presence_i[0] = 1'b1;
      step(1);
      check("pres_lamp_lat", int'(lamp_o[0]), 1);
      check("pres_zone1_off", int'(lamp_o[1]), 0);
      step(2);
      presence_i[0] = 1'b0;
      check_timeout("basic", 0);
      step(3);

      // presence returns while warning (cnt=17)
      presence_i[0] = 1'b1;
      step(2);
      presence_i[0] = 1'b0;
      step(18);
      presence_i[0] = 1'b1;
      step(1);
      check("ret_warn", int'(warn_o[0]), 0);
      check("ret_lamp", int'(lamp_o[0]), 1);
      check("ret_shut", int'(shutdown_o[0]), 0);
      step(2);
      presence_i[0] = 1'b0;
      check_timeout("ret", 0);
      step(2);

      // presence on the exact timeout edge (cnt=19)
      presence_i[0] = 1'b1;
      step(2);
      presence_i[0] = 1'b0;
      step(20);
      presence_i[0] = 1'b1;
      step(1);
      check("coll_lamp", int'(lamp_o[0]), 1);
      check("coll_shut", int'(shutdown_o[0]), 0);
      step(2);
      presence_i[0] = 1'b0;
      check_timeout("coll", 0);
      step(2);

      // manual off with presence held on zone 1
      presence_i[1] = 1'b1;
      step(3);
      manual_off_i[1] = 1'b1;
      step(1);
      manual_off_i[1] = 1'b0;
      check("off_lamp", int'(lamp_o[1]), 0);
      check("off_shut", int'(shutdown_o[1]), 0);
      step(5);
      check("lockout_lamp", int'(lamp_o[1]), 0);
      presence_i[1] = 1'b0;
      step(1);
      presence_i[1] = 1'b1;
      step(1);
      check("relight_lamp", int'(lamp_o[1]), 1);
      presence_i[1] = 1'b0;
      check_timeout("relight", 1);
      step(2);

      // manual on from idle, then on+off together
      manual_on_i[0] = 1'b1;
      check_timeout("mon", 0);
      step(2);
      manual_on_i[0]  = 1'b1;
      manual_off_i[0] = 1'b1;
      step(1);
      check("onoff_lamp", int'(lamp_o[0]), 0);
      manual_on_i[0]  = 1'b0;
      manual_off_i[0] = 1'b0;
      step(2);

      // async reset mid-count (cnt=10)
      presence_i[0] = 1'b1;
      step(2);
      presence_i[0] = 1'b0;
      step(11);
      #2 rst_n = 1'b0;
      #1;
      check("arst_lamp", int'(lamp_o), 0);
      check("arst_warn", int'(warn_o), 0);
      check("arst_shut", int'(shutdown_o), 0);
      check("arst_any",  int'(any_on_o), 0);
      step(2);
      rst_n = 1'b1;
      step(25);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
